// File: rtl/ps2_keyboard_port_pkg.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_port_pkg
// Shared definitions for the PS/2 keyboard port: the bus map (base address,
// register offsets, STATUS bit positions), the receive deframer state type
// and the frame parity helper.
// ----------------------------------------------------------------------------
package ps2_keyboard_port_pkg;

  // Bus map of the keyboard port on the shared 64-bit processor bus.
  localparam logic [63:0] PS2_BASE_ADDR = 64'hFFFF_0010;
  localparam logic [63:0] STATUS_OFS    = 64'd0;
  localparam logic [63:0] DATA_OFS      = 64'd1;

  // STATUS register layout: {56'b0, ovf, perr, 2'b0, count[3:0]}.
  localparam int OVF_BIT  = 7;
  localparam int PERR_BIT = 6;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // A device-to-host frame is good when data plus parity hold an odd number of 1s.
  function automatic logic frame_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_keyboard_port_if.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_port_if
// Processor-side control signals of the keyboard port.
//   address [63:0] : bus address            (master -> slave)
//   read           : read strobe, may be held over several cycles
//   write          : write strobe
//   irq            : high while the scan-code FIFO holds data (slave -> master)
// The 64-bit tristate data bus is shared by several peripherals and is kept as
// a plain inout net on the peripheral so it resolves at the board level.
// ----------------------------------------------------------------------------
interface ps2_keyboard_port_if;
  logic [63:0] address;
  logic        read;
  logic        write;
  logic        irq;

  modport master (output address, output read, output write, input irq);
  modport slave  (input address, input read, input write, output irq);
endinterface

// File: rtl/ps2_keyboard_port_rx_frame.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_port_rx_frame
// Receive half of the PS/2 link: synchronises the raw pins, detects falling
// edges of the PS/2 clock and deframes 11-bit device-to-host frames
// (start 0, 8 data bits LSB first, odd parity, stop 1). A watchdog drops a
// partial frame when the PS/2 clock has been silent for TIMEOUT cycles.
// Ports:
//   clock, reset_n      : system clock, async active-low reset
//   ps2_clk, ps2_dat    : raw asynchronous PS/2 pins
//   code[7:0]           : last accepted scan code
//   code_valid          : 1-cycle pulse, code holds a new good scan code
//   parity_err          : 1-cycle pulse, frame failed parity or stop check
// ----------------------------------------------------------------------------
module ps2_keyboard_port_rx_frame
  import ps2_keyboard_port_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic            ck_q0, ck_q1, ck_q2;
  logic            dt_q0, dt_q1;
  logic            fall_s;
  rx_state_e       state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [WD_W-1:0] wd_q;
  logic [7:0]      code_q;
  logic            valid_q;
  logic            perr_q;

  // Pin synchronizers; reset to the idle-high line level so no false edge appears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ck_q0 <= 1'b1;
      ck_q1 <= 1'b1;
      ck_q2 <= 1'b1;
      dt_q0 <= 1'b1;
      dt_q1 <= 1'b1;
    end else begin
      ck_q0 <= ps2_clk;
      ck_q1 <= ck_q0;
      ck_q2 <= ck_q1;
      dt_q0 <= ps2_dat;
      dt_q1 <= dt_q0;
    end
  end

  assign fall_s = ck_q2 & ~ck_q1;

  // Deframer FSM with watchdog; outputs are registered pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      wd_q      <= '0;
      code_q    <= 8'h00;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      if (fall_s) begin
        wd_q <= '0;
        case (state_q)
          RX_IDLE: begin
            // A high start bit is ignored; wait for a proper start.
            if (!dt_q1) begin
              state_q   <= RX_SHIFT;
              bit_cnt_q <= 3'd0;
            end else begin
              state_q <= RX_IDLE;
            end
          end
          RX_SHIFT: begin
            shift_q   <= {dt_q1, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= RX_PARITY;
            end else begin
              state_q <= RX_SHIFT;
            end
          end
          RX_PARITY: begin
            par_q   <= dt_q1;
            state_q <= RX_STOP;
          end
          RX_STOP: begin
            if (dt_q1 && frame_parity_ok(shift_q, par_q)) begin
              code_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              perr_q <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
          default: begin
            state_q <= RX_IDLE;
          end
        endcase
      end else if (state_q != RX_IDLE) begin
        // Silent PS/2 clock mid-frame: abandon the frame without flagging it.
        if (wd_q == WD_LAST) begin
          state_q <= RX_IDLE;
          wd_q    <= '0;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end else begin
        wd_q <= '0;
      end
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign parity_err = perr_q;

endmodule

// File: rtl/ps2_keyboard_port.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_port
// Memory-mapped PS/2 keyboard receiver. Received scan codes are queued in a
// FIFO; the processor polls STATUS (BASE_ADDR) and pops codes by reading
// DATA (BASE_ADDR+1). Receive only: the PS/2 lines are never driven.
// Ports:
//   clock, reset_n   : 50 MHz system clock, async active-low reset
//   ps2_clk, ps2_dat : raw PS/2 keyboard pins
//   data[63:0]       : shared tristate bus, driven only on a read hit
//   bus              : address/read/write strobes and irq (slave modport)
// STATUS = {56'b0, ovf, perr, 2'b0, count[3:0]}; DATA = {56'b0, head} or 0.
// Writing STATUS with bit7/bit6 set clears ovf/perr.
// ----------------------------------------------------------------------------
module ps2_keyboard_port
  import ps2_keyboard_port_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = PS2_BASE_ADDR,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 50000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ps2_clk,
  input  logic                ps2_dat,
  inout  wire  [63:0]         data,
  ps2_keyboard_port_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [7:0]       rx_code_s;
  logic             rx_valid_s;
  logic             rx_perr_s;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             perr_q, perr_d;
  logic             rd_data_q;
  logic             irq_q;

  logic             hit_status_s, hit_data_s;
  logic             rd_data_s, rd_any_s, wr_status_s;
  logic             full_s, empty_s, push_s, pop_s;
  logic [63:0]      rd_val_s;

  ps2_keyboard_port_rx_frame #(
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .code       (rx_code_s),
    .code_valid (rx_valid_s),
    .parity_err (rx_perr_s)
  );

  assign hit_status_s = (bus.address == (BASE_ADDR + STATUS_OFS));
  assign hit_data_s   = (bus.address == (BASE_ADDR + DATA_OFS));
  assign rd_data_s    = bus.read & hit_data_s;
  assign rd_any_s     = bus.read & (hit_status_s | hit_data_s);
  // A simultaneous read wins, so the write is dropped.
  assign wr_status_s  = bus.write & ~bus.read & hit_status_s;

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == '0);
  // Pop on the trailing edge of a DATA read so the value is stable throughout the strobe.
  assign pop_s   = rd_data_q & ~rd_data_s & ~empty_s;
  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign push_s  = rx_valid_s & (~full_s | pop_s);

  // Next count and sticky flags; a new error wins over a clear in the same cycle.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d  = (ovf_q  & ~(wr_status_s & data[OVF_BIT]))  | (rx_valid_s & full_s & ~pop_s);
    perr_d = (perr_q & ~(wr_status_s & data[PERR_BIT])) | rx_perr_s;
  end

  // Read mux for the two registers.
  always_comb begin
    rd_val_s = 64'h0;
    if (hit_data_s) begin
      if (!empty_s) begin
        rd_val_s[7:0] = mem_q[rd_ptr_q];
      end else begin
        rd_val_s = 64'h0;
      end
    end else begin
      rd_val_s[OVF_BIT]     = ovf_q;
      rd_val_s[PERR_BIT]    = perr_q;
      rd_val_s[CNT_W-1:0]   = count_q;
    end
  end

  assign data = rd_any_s ? rd_val_s : {64{1'bz}};

  // FIFO storage, pointers, flags and the registered irq.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
      rd_data_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= rx_code_s;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
      rd_data_q <= rd_data_s;
      irq_q     <= (count_d != '0);
    end
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_ps2_keyboard_port.sv
// ----------------------------------------------------------------------------
// tb_ps2_keyboard_port
// Drives PS/2 frames and bus cycles into ps2_keyboard_port and compares every
// STATUS, DATA and irq observation with a queue-based model of the port.
// ----------------------------------------------------------------------------
module tb_ps2_keyboard_port;
  import ps2_keyboard_port_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 10;
  localparam logic [63:0] A_STATUS = PS2_BASE_ADDR + STATUS_OFS;
  localparam logic [63:0] A_DATA   = PS2_BASE_ADDR + DATA_OFS;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        tb_drv  = 1'b0;
  logic [63:0] tb_wdata = 64'h0;
  wire  [63:0] data;

  assign data = tb_drv ? tb_wdata : {64{1'bz}};

  ps2_keyboard_port_if bus ();

  ps2_keyboard_port #(
    .BASE_ADDR  (PS2_BASE_ADDR),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .data    (data),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] model_q [$];
  logic       m_ovf  = 1'b0;
  logic       m_perr = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [63:0] exp_status();
    logic [63:0] v;
    v = 64'h0;
    v[7] = m_ovf;
    v[6] = m_perr;
    v[3:0] = 4'(model_q.size());
    return v;
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // Model of a received frame: good frames queue or overflow, bad ones flag perr.
  task automatic model_frame(input logic [7:0] c, input bit bad);
    if (bad) begin
      m_perr = 1'b1;
    end else if (model_q.size() < FIFO_DEPTH) begin
      model_q.push_back(c);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^c) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(par);
    ps2_bit(bad_stop ? 1'b0 : 1'b1);
    ps2_dat = 1'b1;
    wait_cyc(HALF);
    model_frame(c, bad_par | bad_stop);
  endtask

  task automatic check_status(input string tag);
    bus.address = A_STATUS;
    bus.read    = 1'b1;
    wait_cyc(1);
    check_eq({tag, "_status"}, data, exp_status());
    bus.read = 1'b0;
    wait_cyc(1);
    check_eq({tag, "_irq"}, {63'h0, bus.irq}, {63'h0, model_q.size() != 0});
  endtask

  // DATA read strobe of ncyc cycles; the value must hold for the whole strobe.
  task automatic read_data(input string tag, input int ncyc);
    logic [63:0] exp;
    exp = (model_q.size() != 0) ? {56'h0, model_q[0]} : 64'h0;
    bus.address = A_DATA;
    bus.read    = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      wait_cyc(1);
      check_eq({tag, "_data"}, data, exp);
    end
    bus.read = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
    wait_cyc(2);
  endtask

  task automatic write_reg(input logic [63:0] addr, input logic [63:0] v);
    bus.address = addr;
    tb_wdata    = v;
    tb_drv      = 1'b1;
    bus.write   = 1'b1;
    wait_cyc(1);
    bus.write = 1'b0;
    tb_drv    = 1'b0;
    wait_cyc(1);
    if (addr == A_STATUS) begin
      if (v[7]) m_ovf = 1'b0;
      if (v[6]) m_perr = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] c;
    int         k;
    bus.address = 64'h0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;

    // Reset state, observed while reset_n is low.
    wait_cyc(3);
    check_status("reset");
    reset_n = 1'b1;
    wait_cyc(3);

    // Make code for 'A'.
    send_frame(8'h1C, 1'b0, 1'b0);
    check_status("one_code");
    read_data("one_code", 1);
    check_status("after_pop");

    // Parity error, then clear it.
    send_frame(8'h1C, 1'b1, 1'b0);
    check_status("perr");
    write_reg(A_STATUS, 64'h40);
    check_status("perr_clr");

    // Overflow: nine codes into eight slots.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    check_status("ovf");
    for (int i = 0; i < 9; i++) read_data("drain", 1);
    check_status("drained");
    write_reg(A_DATA, 64'hC0);
    check_status("wr_data_ignored");
    write_reg(A_STATUS, 64'h80);
    check_status("ovf_clr");

    // Partial frame abandoned by the watchdog.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_dat = 1'b1;
    wait_cyc(TIMEOUT + 100);
    send_frame(8'hF0, 1'b0, 1'b0);
    check_status("timeout");
    read_data("timeout", 1);

    // Push lands in the middle of a long DATA strobe.
    send_frame(8'h55, 1'b0, 1'b0);
    ps2_bit(1'b0);
    c = 8'h3A;
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(~^c);
    ps2_dat = 1'b1;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    model_frame(c, 1'b0);
    read_data("mid_strobe", 6);
    ps2_clk = 1'b1;
    wait_cyc(HALF);
    check_status("mid_strobe");

    // Non-matching address read must not pop.
    bus.address = PS2_BASE_ADDR + 64'd2;
    bus.read    = 1'b1;
    wait_cyc(3);
    bus.read = 1'b0;
    wait_cyc(2);
    check_status("miss_read");

    // Reset in the middle of a frame.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset_n = 1'b0;
    wait_cyc(3);
    model_q.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    reset_n = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(3);
    check_status("mid_reset");
    send_frame(8'h2B, 1'b0, 1'b0);
    check_status("post_reset");
    read_data("post_reset", 1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      c = 8'($urandom);
      k = $urandom_range(0, 7);
      send_frame(c, k == 0, k == 1);
      case ($urandom_range(0, 3))
        0: read_data("rnd", $urandom_range(1, 3));
        1: begin
          k = $urandom_range(0, 2);
          write_reg(A_STATUS, (k == 0) ? 64'h80 : (k == 1) ? 64'h40 : 64'hC0);
        end
        default: wait_cyc(1);
      endcase
      check_status("rnd");
    end
    while (model_q.size() != 0) read_data("rnd_drain", 1);
    read_data("rnd_empty", 1);
    check_status("rnd_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
